// File: rtl/tiny_bus_bridge.sv
// Narrow valid/ready host bus to wide GF(3^M) core RAM bridge: beat assembly, commit,
// read-back serialisation and core run control. Optional watchdog: BRIDGE_TIMEOUT_EN.
module tiny_bus_bridge #(
  parameter int M           = 593,
  parameter int BUS_W       = 32,
  parameter int ADDR_W      = 6,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic [1:0]        h_op,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [BUS_W-1:0]  h_wdata,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [BUS_W-1:0]  r_data,
  output logic              r_last,
  output logic              run_done,
  output logic              err,
  output logic              core_reset,
  output logic              core_sel,
  output logic              core_w,
  output logic [ADDR_W-1:0] core_addr,
  output logic [2*M+1:0]    core_data,
  input  logic [2*M+1:0]    core_out,
  input  logic              core_done
);
  localparam int W      = 2*M+2;
  localparam int NBEATS = (W + BUS_W - 1) / BUS_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_START = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_WCOMMIT, S_RREQ, S_RWAIT, S_RSEND, S_RUN
  } state_t;

  state_t              r_state;
  logic [BEAT_W-1:0]   r_beat;
  logic [LAT_W-1:0]    r_wait;
  logic [W-1:0]        r_asm;
  logic [W-1:0]        r_cap;
  logic                r_first;
  logic [W-1:0]        w_asm_nxt;
  logic [BEAT_W-1:0]   w_beat_idx;
  logic                w_accept;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]     r_tcnt;
`endif

  assign h_ready    = (r_state == S_IDLE) || (r_state == S_WLOAD);
  assign w_accept   = h_valid && h_ready;
  assign w_beat_idx = (r_state == S_WLOAD) ? r_beat : '0;
  // The capture register shifts down one word per beat, so padding above W reads as zero.
  assign r_data     = r_cap[BUS_W-1:0];

  // Bits of the final beat that fall above W never reach the register.
  always_comb begin
    w_asm_nxt = r_asm;
    for (int i = 0; i < W; i++)
      if (BEAT_W'(i / BUS_W) == w_beat_idx) w_asm_nxt[i] = h_wdata[i % BUS_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_wait     <= '0;
      r_asm      <= '0;
      r_cap      <= '0;
      r_first    <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      run_done   <= 1'b0;
      err        <= 1'b0;
      core_reset <= 1'b1;
      core_sel   <= 1'b0;
      core_w     <= 1'b0;
      core_addr  <= '0;
      core_data  <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      r_tcnt     <= '0;
`endif
    end else begin
      core_sel <= 1'b0;
      core_w   <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          case (h_op)
            OP_WRITE: begin
              core_addr  <= h_addr;
              core_reset <= 1'b1;
              r_asm      <= w_asm_nxt;
              if (NBEATS == 1) begin
                core_data <= w_asm_nxt;
                core_sel  <= 1'b1;
                core_w    <= 1'b1;
                r_state   <= S_WCOMMIT;
              end else begin
                r_beat  <= BEAT_W'(1);
                r_state <= S_WLOAD;
              end
            end
            OP_READ: begin
              core_addr <= h_addr;
              core_sel  <= 1'b1;
              r_state   <= S_RREQ;
            end
            OP_START: begin
              run_done   <= 1'b0;
              err        <= 1'b0;
              core_reset <= 1'b0;
              r_first    <= 1'b1;
`ifdef BRIDGE_TIMEOUT_EN
              r_tcnt     <= '0;
`endif
              r_state    <= S_RUN;
            end
            default: err <= 1'b1;
          endcase
        end
        S_WLOAD: if (w_accept) begin
          if (h_op == OP_WRITE) begin
            r_asm <= w_asm_nxt;
            if (r_beat == BEAT_W'(NBEATS-1)) begin
              core_data <= w_asm_nxt;
              core_sel  <= 1'b1;
              core_w    <= 1'b1;
              r_state   <= S_WCOMMIT;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end else begin
            err     <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_WCOMMIT: r_state <= S_IDLE;
        S_RREQ: begin
          r_wait  <= LAT_W'(RD_LAT-1);
          r_state <= S_RWAIT;
        end
        S_RWAIT: begin
          if (r_wait == '0) begin
            r_cap   <= core_out;
            r_beat  <= '0;
            r_valid <= 1'b1;
            r_last  <= (NBEATS == 1);
            r_state <= S_RSEND;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_RSEND: if (r_ready) begin
          if (r_beat == BEAT_W'(NBEATS-1)) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cap  <= r_cap >> BUS_W;
            r_beat <= r_beat + 1'b1;
            r_last <= (r_beat == BEAT_W'(NBEATS-2));
          end
        end
        S_RUN: begin
          r_first <= 1'b0;
          // The first RUN cycle may still see a stale done from the previous run.
          if (!r_first && core_done) begin
            run_done <= 1'b1;
            r_state  <= S_IDLE;
          end
`ifdef BRIDGE_TIMEOUT_EN
          else if (r_tcnt == TO_W'(TIMEOUT_CYC-1)) begin
            err        <= 1'b1;
            core_reset <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tiny_bus_bridge.sv
// Directed bench for tiny_bus_bridge: cycle vector table plus hand sequences for
// load, read-back, run, abort, mid-load reset and (with BRIDGE_TIMEOUT_EN) watchdog.
module tb_tiny_bus_bridge;
  localparam int M = 593, BUS_W = 32, ADDR_W = 6, RD_LAT = 1, TO = 64;
  localparam int W = 2*M+2, NB = 38, NBW = NB*32;

  logic clk = 0, reset = 1;
  logic h_valid = 0, h_ready, r_valid, r_ready = 0, r_last;
  logic [1:0] h_op = 0;
  logic [ADDR_W-1:0] h_addr = 0, core_addr;
  logic [BUS_W-1:0] h_wdata = 0, r_data;
  logic run_done, err, core_reset, core_sel, core_w, core_done;
  logic [W-1:0] core_data, core_out;

  int checks = 0, failures = 0;
  int sel_cnt = 0, wr_cnt = 0;
  logic [ADDR_W-1:0] wr_addr;
  logic [W-1:0] mem [64];
  logic [31:0] rc = 0;
  logic done_en = 0, done_force = 0;

  tiny_bus_bridge #(.M(M), .BUS_W(BUS_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .h_valid(h_valid), .h_ready(h_ready), .h_op(h_op),
    .h_addr(h_addr), .h_wdata(h_wdata), .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data), .r_last(r_last), .run_done(run_done), .err(err),
    .core_reset(core_reset), .core_sel(core_sel), .core_w(core_w),
    .core_addr(core_addr), .core_data(core_data), .core_out(core_out), .core_done(core_done));

  always #5 clk = ~clk;

  // Core model: one-cycle read latency, done pulse 100 cycles after core_reset falls.
  assign core_done = done_force | (done_en && !core_reset && rc == 32'd100);
  always @(posedge clk) begin
    rc <= core_reset ? 32'd0 : rc + 32'd1;
    if (core_sel) sel_cnt <= sel_cnt + 1;
    if (core_sel && core_w) begin
      wr_cnt <= wr_cnt + 1;
      wr_addr <= core_addr;
      mem[core_addr] <= core_data;
    end
    if (core_sel && !core_w) core_out <= mem[core_addr];
  end

  typedef struct {
    logic v; logic [1:0] op; logic done; logic [6:0] exp;  // exp = {hr,err,rd,cr,sel,w,rv}
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmpw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    logic [NBW-1:0] a, e;
    int bad;
    a = NBW'(act); e = NBW'(exp); bad = -1;
    for (int k = NB-1; k >= 0; k--) if (a[32*k +: 32] !== e[32*k +: 32]) bad = k;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: word %0d got %h expected %h", nm, bad, a[32*bad +: 32], e[32*bad +: 32]);
    end
  endtask

  function automatic logic [W-1:0] pat();
    logic [NBW-1:0] t;
    for (int k = 0; k < NB; k++) t[32*k +: 32] = (32'h9E3779B9 * 32'(k+1)) ^ 32'hA5A50000;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] wexp(input int base);
    logic [NBW-1:0] t;
    for (int k = 0; k < NB; k++) t[32*k +: 32] = 32'(base + k);
    return t[W-1:0];
  endfunction

  task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    h_valid = 1; h_op = op; h_addr = a; h_wdata = d;
    while (!h_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_timeout", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    h_valid = 0;
  endtask

  task automatic write_block(input logic [ADDR_W-1:0] a, input int base);
    for (int i = 0; i < NB; i++) send(2'd0, a, 32'(base + i));
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input bit toggle,
                         output logic [W-1:0] data, output int lat, output int lastbad,
                         output logic [NBW-W-1:0] pad);
    logic [NBW-1:0] buff;
    int k, n;
    send(2'd1, a, 32'd0);
    lat = 1; n = 0; k = 0; lastbad = 0; buff = '0;
    while (!r_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    r_ready = 0;
    while (k < NB && n < 400) begin
      r_ready = toggle ? ~r_ready : 1'b1;
      if (r_valid && r_ready) begin
        buff[32*k +: 32] = r_data;
        if (r_last !== (k == NB-1)) lastbad++;
        k++;
      end
      @(posedge clk); #1; n++;
    end
    r_ready = 0;
    chk("read_beats", 64'(k), 64'(NB));
    data = buff[W-1:0];
    pad = buff[NBW-1:W];
  endtask

  initial begin
    logic [W-1:0] rd;
    logic [NBW-W-1:0] pad;
    int lat, lb, n, s0;
    mem[9] = pat();
    // Reset held with a beat presented.
    h_valid = 1; h_op = 0; h_addr = 3; h_wdata = 32'hdead;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {h_ready, core_reset, err, run_done, core_sel, core_w, r_valid, r_last},
        8'b11000000);
    chk("rst_data", {r_data, 26'(core_addr), 6'(|core_data)}, 64'd0);
    h_valid = 0; reset = 0;
    @(posedge clk); #1;
    chk("rst_release", {h_ready, core_reset, 30'(wr_cnt)}, {2'b11, 30'd0});

    tbl[0]  = '{1'b0, 2'd0, 1'b0, 7'b1001000};
    tbl[1]  = '{1'b1, 2'd3, 1'b0, 7'b1101000};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 7'b0000000};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 7'b0000000};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 7'b0000000};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 7'b1010000};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 7'b1011000};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 7'b1111000};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 7'b0000000};
    tbl[9]  = '{1'b0, 2'd0, 1'b1, 7'b0000000};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 7'b1010000};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 7'b0010100};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 7'b0010000};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 7'b0010001};
    for (int i = 0; i < 14; i++) begin
      h_valid = tbl[i].v; h_op = tbl[i].op; h_addr = 0; h_wdata = 0; done_force = tbl[i].done;
      @(posedge clk); #1;
      checks++;
      if ({h_ready, err, run_done, core_reset, core_sel, core_w, r_valid} !== tbl[i].exp) begin
        failures++;
        $display("FAIL vec%0d: got %b expected %b", i,
                 {h_ready, err, run_done, core_reset, core_sel, core_w, r_valid}, tbl[i].exp);
      end
    end
    h_valid = 0; done_force = 0;
    r_ready = 1; n = 0;
    while (r_valid && n < 100) begin @(posedge clk); #1; n++; end
    r_ready = 0;
    chk("drain_cycles", 64'(n), 64'(NB));

    // Full load to addr 3, beat i carries i.
    s0 = wr_cnt;
    write_block(6'd3, 0);
    chk("commit_strobe", {core_sel, core_w, core_reset, 5'(core_addr)}, {3'b111, 5'd3});
    cmpw("commit_data", core_data, wexp(0));
    @(posedge clk); #1;
    chk("commit_hready", {h_ready, core_sel}, 2'b10);
    chk("commit_count", 64'(wr_cnt - s0), 64'd1);
    chk("top_nibble", 64'(core_data[1187:1184]), 64'h5);

    // Read-back under toggling backpressure.
    do_read(6'd9, 1'b1, rd, lat, lb, pad);
    cmpw("read9_data", rd, pat());
    chk("read9_lat", 64'(lat), 64'(2 + RD_LAT));
    chk("read9_pad", 64'(pad), 64'd0);
    chk("read9_last", 64'(lb), 64'd0);
    chk("read9_idle", {h_ready, r_valid, r_last}, 3'b100);

    // Run with the core answering 100 cycles after core_reset falls.
    done_en = 1;
    send(2'd2, 6'd0, 32'd0);
    chk("start_clr", {core_reset, run_done, err}, 3'b000);
    n = 0;
    while (!run_done && n < 300) begin @(posedge clk); #1; n++; end
    done_en = 0;
    chk("run_done_lat", 64'(n), 64'd101);
    chk("run_after", {run_done, core_reset, h_ready}, 3'b101);
    do_read(6'd3, 1'b0, rd, lat, lb, pad);
    cmpw("read3_data", rd, wexp(0));
    chk("read3_core_reset", {core_reset, 6'(lb)}, 7'd0);
    send(2'd0, 6'd5, 32'd1);
    chk("write_raises_cr", {core_reset, h_ready}, 2'b11);

    // Aborted load: 5 write beats then a read beat.
    for (int i = 1; i < 5; i++) send(2'd0, 6'd5, 32'(i + 1));
    s0 = sel_cnt;
    send(2'd1, 6'd5, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_state", {err, h_ready, r_valid}, 3'b110);
    chk("abort_nosel", 64'(sel_cnt - s0), 64'd0);
    send(2'd2, 6'd0, 32'd0);
    chk("start_clears_err", {err, core_reset}, 2'b00);
    @(posedge clk); #1;
    done_force = 1;
    @(posedge clk); #1;
    done_force = 0;
    chk("forced_done", {run_done, h_ready}, 2'b11);

    // Asynchronous reset mid-load, then a clean load must still take 38 beats.
    send(2'd0, 6'd7, 32'hAAAA);
    send(2'd0, 6'd7, 32'hBBBB);
    #3 reset = 1;
    #1;
    chk("midrst", {h_ready, core_reset, err, run_done, core_sel, r_valid, 1'b0, |core_data},
        8'b11000000);
    @(posedge clk); #1 reset = 0;
    s0 = wr_cnt;
    for (int i = 0; i < NB-1; i++) send(2'd0, 6'd7, 32'(100 + i));
    chk("midrst_no_early", {core_sel, 7'(wr_cnt - s0)}, 8'd0);
    send(2'd0, 6'd7, 32'(100 + NB - 1));
    chk("midrst_commit", {core_sel, core_w, 6'(core_addr)}, {2'b11, 6'd7});
    cmpw("midrst_data", core_data, wexp(100));

`ifdef BRIDGE_TIMEOUT_EN
    send(2'd2, 6'd0, 32'd0);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("to_early", {err, core_reset, h_ready}, 3'b000);
    @(posedge clk); #1;
    chk("to_fire", {err, core_reset, run_done, h_ready}, 4'b1101);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
